clk_div_ramp_ctrl: RTL and testbench

Sequencer and arbiter placed in front of the integer clock divider's `div`/`div_valid`/`div_ready` handshake. Several requesters (power manager, debug, software CSR) ask for a target divide ratio. The block grants one request at a time in round-robin order. It then walks the divider from its current ratio to the target in unit steps, holding each intermediate ratio for a programmable dwell time, so load current changes gradually instead of jumping.

---
 rtl/clk_div_ramp_ctrl.sv | 165 ++++++++++++++++
 tb/tb_clk_div_ramp_ctrl.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clk_div_ramp_ctrl.sv
// Round-robin request arbiter and unit-step ramp sequencer in front of the
// integer clock divider's div/div_valid/div_ready handshake. Each intermediate
// ratio is held for dwell_i cycles so load current changes gradually.
module clk_div_ramp_ctrl #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned DIV_VALUE_WIDTH = 4,
    parameter int unsigned DWELL_WIDTH     = 8,
    parameter int unsigned RESET_DIV       = 1,
    localparam int unsigned GRANT_W        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                                 clk_i,
    input  logic                                 rst_ni,
    input  logic [NUM_REQ-1:0]                   req_valid_i,
    input  logic [NUM_REQ*DIV_VALUE_WIDTH-1:0]   req_div_i,
    output logic [NUM_REQ-1:0]                   req_ready_o,
    input  logic [DWELL_WIDTH-1:0]               dwell_i,
    output logic [DIV_VALUE_WIDTH-1:0]           div_o,
    output logic                                 div_valid_o,
    input  logic                                 div_ready_i,
    output logic [DIV_VALUE_WIDTH-1:0]           cur_div_o,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic [GRANT_W-1:0]                   grant_id_o
);

    // A ratio of 0 is meaningless to the divider; it is treated as 1.
    localparam logic [DIV_VALUE_WIDTH-1:0] RESET_DIV_N =
        (RESET_DIV == 0) ? DIV_VALUE_WIDTH'(1) : DIV_VALUE_WIDTH'(RESET_DIV);

    typedef enum logic [1:0] {
        IDLE,
        STEP,
        DWELL,
        DONE
    } state_e;

    state_e                     state_q, state_d;
    logic [DIV_VALUE_WIDTH-1:0] cur_div_q;
    logic [DIV_VALUE_WIDTH-1:0] tgt_q;
    logic [DWELL_WIDTH-1:0]     cnt_q;
    logic [GRANT_W-1:0]         rr_ptr_q;
    logic [GRANT_W-1:0]         grant_id_q;

    logic                       found;
    logic [GRANT_W-1:0]         winner;
    logic [GRANT_W-1:0]         rr_next;
    logic [DIV_VALUE_WIDTH-1:0] sel_div;
    logic [DIV_VALUE_WIDTH-1:0] acc_tgt;
    logic [DIV_VALUE_WIDTH-1:0] step_div;
    logic                       accept;
    logic                       handshake;

    // Round-robin search: first pass covers rr_ptr_q..NUM_REQ-1, second pass
    // falls back to the lowest index, which is the wrapped continuation.
    always_comb begin
        found   = 1'b0;
        winner  = '0;
        sel_div = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i] && (GRANT_W'(i) >= rr_ptr_q)) begin
                found  = 1'b1;
                winner = GRANT_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (!found && req_valid_i[i]) begin
                found  = 1'b1;
                winner = GRANT_W'(i);
            end
        end
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (GRANT_W'(i) == winner) begin
                sel_div = req_div_i[i*DIV_VALUE_WIDTH +: DIV_VALUE_WIDTH];
            end
        end
        acc_tgt = (sel_div == '0) ? DIV_VALUE_WIDTH'(1) : sel_div;
        rr_next = (winner == GRANT_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
    end

    // Next-state and handshake outputs; the step ratio always moves one unit
    // toward the latched target, so it cannot leave 1..2^W-1.
    always_comb begin
        state_d     = state_q;
        req_ready_o = '0;
        div_valid_o = 1'b0;
        div_o       = cur_div_q;
        accept      = 1'b0;
        handshake   = 1'b0;
        step_div    = (tgt_q > cur_div_q) ? cur_div_q + 1'b1 : cur_div_q - 1'b1;
        case (state_q)
            IDLE: begin
                if (found) begin
                    accept = 1'b1;
                    for (int unsigned i = 0; i < NUM_REQ; i++) begin
                        req_ready_o[i] = (GRANT_W'(i) == winner);
                    end
                    state_d = (acc_tgt == cur_div_q) ? DONE : STEP;
                end
            end
            STEP: begin
                div_valid_o = 1'b1;
                div_o       = step_div;
                if (div_ready_i) begin
                    handshake = 1'b1;
                    if (step_div == tgt_q) begin
                        state_d = DONE;
                    end else if (dwell_i == '0) begin
                        state_d = STEP;
                    end else begin
                        state_d = DWELL;
                    end
                end
            end
            DWELL: begin
                if (cnt_q == '0) begin
                    state_d = STEP;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Grant bookkeeping, accepted ratio and dwell countdown.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cur_div_q  <= RESET_DIV_N;
            tgt_q      <= RESET_DIV_N;
            cnt_q      <= '0;
            rr_ptr_q   <= '0;
            grant_id_q <= '0;
        end else begin
            if (accept) begin
                tgt_q      <= acc_tgt;
                grant_id_q <= winner;
                rr_ptr_q   <= rr_next;
            end
            if (handshake) begin
                cur_div_q <= step_div;
                cnt_q     <= dwell_i - 1'b1;
            end else if ((state_q == DWELL) && (cnt_q != '0)) begin
                cnt_q <= cnt_q - 1'b1;
            end
        end
    end

    assign cur_div_o  = cur_div_q;
    assign busy_o     = (state_q != IDLE);
    assign done_o     = (state_q == DONE);
    assign grant_id_o = grant_id_q;

endmodule

// File: tb/tb_clk_div_ramp_ctrl.sv
// Scoreboard bench for clk_div_ramp_ctrl: stimulus pushes expected accepts,
// divider steps and completions; a negedge monitor pops and compares them.
module tb_clk_div_ramp_ctrl;

    localparam int N  = 2;
    localparam int W  = 4;
    localparam int DW = 8;

    logic            clk = 1'b0;
    logic            rst_ni;
    logic [N-1:0]    req_valid;
    logic [N*W-1:0]  req_div;
    logic [N-1:0]    req_ready;
    logic [DW-1:0]   dwell;
    logic [W-1:0]    div_o;
    logic            div_valid;
    logic            div_ready;
    logic [W-1:0]    cur_div;
    logic            busy;
    logic            done;
    logic [0:0]      grant_id;

    clk_div_ramp_ctrl #(
        .NUM_REQ         (N),
        .DIV_VALUE_WIDTH (W),
        .DWELL_WIDTH     (DW),
        .RESET_DIV       (1)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .req_valid_i (req_valid),
        .req_div_i   (req_div),
        .req_ready_o (req_ready),
        .dwell_i     (dwell),
        .div_o       (div_o),
        .div_valid_o (div_valid),
        .div_ready_i (div_ready),
        .cur_div_o   (cur_div),
        .busy_o      (busy),
        .done_o      (done),
        .grant_id_o  (grant_id)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: actual %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    typedef struct { int div; int gap; } step_t;
    typedef struct { int id;  int div; } done_t;

    step_t step_q[$];
    done_t done_q[$];
    int    acc_q[$];

    // Reference model: current ratio and round-robin pointer.
    int m_cur = 1;
    int m_rr  = 0;

    function automatic int pick_winner(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            int idx;
            idx = (m_rr + k) % N;
            if (v[idx]) return idx;
        end
        return -1;
    endfunction

    // Expected transactions for one granted request: one unit step per
    // divider handshake, first valid 1 cycle after accept, later ones
    // dwell+1 cycles after the previous handshake, then a done.
    task automatic push_txn(input int id, input int t, input int d);
        int    tg;
        bit    first;
        step_t s;
        done_t dn;
        tg    = (t == 0) ? 1 : t;
        first = 1'b1;
        acc_q.push_back(1 << id);
        while (m_cur != tg) begin
            m_cur  = (tg > m_cur) ? m_cur + 1 : m_cur - 1;
            s.div  = m_cur;
            s.gap  = first ? 1 : d + 1;
            step_q.push_back(s);
            first  = 1'b0;
        end
        dn.id  = id;
        dn.div = tg;
        done_q.push_back(dn);
        m_rr = (id + 1) % N;
    endtask

    // Divider-side ready: 0 = always ready, 1 = ready after 2 waiting
    // cycles, other = random (also toggles outside STEP).
    int rdy_mode = 0;
    always @(posedge clk) begin
        int vcnt;
        #1;
        case (rdy_mode)
            0: div_ready = 1'b1;
            1: begin
                div_ready = div_valid && (vcnt == 2);
                vcnt      = (div_valid && vcnt < 2) ? vcnt + 1 : 0;
            end
            default: div_ready = ($urandom_range(0, 2) == 0);
        endcase
    end

    // Monitor.
    int mon_cur  = 1;
    bit mon_busy = 1'b0;
    bit in_txn   = 1'b0;
    int last_evt = 0;
    always @(negedge clk) begin
        if (!rst_ni) begin
            mon_cur  = 1;
            mon_busy = 1'b0;
            in_txn   = 1'b0;
            last_evt = cyc;
        end else begin
            done_t dn;
            check("busy", busy, mon_busy);
            check("cur_div", cur_div, mon_cur);
            if (req_ready != '0) begin
                if (acc_q.size() == 0) check("unexpected_accept", req_ready, 0);
                else check("accept_onehot", req_ready, acc_q.pop_front());
                mon_busy = 1'b1;
                last_evt = cyc;
            end
            if (div_valid) begin
                if (step_q.size() == 0) begin
                    check("unexpected_valid", div_valid, 0);
                end else begin
                    if (!in_txn) begin
                        check("step_gap", cyc - last_evt, step_q[0].gap);
                        in_txn = 1'b1;
                    end
                    check("div_o_step", div_o, step_q[0].div);
                    if (div_ready) begin
                        mon_cur  = step_q[0].div;
                        void'(step_q.pop_front());
                        in_txn   = 1'b0;
                        last_evt = cyc;
                    end
                end
            end else begin
                check("div_o_hold", div_o, mon_cur);
            end
            if (done) begin
                if (done_q.size() == 0) begin
                    check("unexpected_done", done, 0);
                end else begin
                    dn = done_q.pop_front();
                    check("done_grant_id", grant_id, dn.id);
                    check("done_cur_div", cur_div, dn.div);
                    check("done_gap", cyc - last_evt, 1);
                end
                mon_busy = 1'b0;
                last_evt = cyc;
            end
        end
    end

    // Keep driving valids until each asserted requester has been accepted.
    task automatic drive_until_accepted();
        logic [N-1:0] acc;
        int budget;
        budget = 0;
        while (req_valid != '0 && budget < 1000) begin
            @(negedge clk);
            acc = req_ready;
            @(posedge clk);
            #1;
            req_valid = req_valid & ~acc;
            budget++;
        end
        if (req_valid != '0) begin
            check("accept_timeout", req_valid, 0);
            req_valid = '0;
        end
    endtask

    task automatic wait_idle();
        int budget;
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while ((step_q.size() + done_q.size() + acc_q.size() != 0 || busy) && budget < 2000);
        if (budget >= 2000) begin
            check("idle_timeout", step_q.size() + done_q.size() + acc_q.size() + int'(busy), 0);
            step_q.delete();
            done_q.delete();
            acc_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run_req(input int id, input int t, input int d);
        dwell = DW'(d);
        req_div[id*W +: W] = W'(t);
        push_txn(id, t, d);
        req_valid[id] = 1'b1;
        drive_until_accepted();
        wait_idle();
    endtask

    task automatic run_pair(input int t0, input int t1, input int d);
        int w, o, tw, to;
        dwell = DW'(d);
        req_div[0*W +: W] = W'(t0);
        req_div[1*W +: W] = W'(t1);
        w  = pick_winner(2'b11);
        o  = 1 - w;
        tw = (w == 0) ? t0 : t1;
        to = (o == 0) ? t0 : t1;
        push_txn(w, tw, d);
        push_txn(o, to, d);
        req_valid = 2'b11;
        drive_until_accepted();
        wait_idle();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_div_valid"}, div_valid, 0);
        check({tag, "_req_ready"}, req_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
        check({tag, "_grant_id"}, grant_id, 0);
        check({tag, "_div_o"}, div_o, 1);
        check({tag, "_cur_div"}, cur_div, 1);
    endtask

    initial begin
        int budget;
        rst_ni    = 1'b0;
        req_valid = '0;
        req_div   = '0;
        dwell     = '0;
        div_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst_ni = 1'b1;
        @(posedge clk);
        #1;

        // Zero target with cur=1: completes without a divider transaction.
        run_req(0, 0, 2);
        // Ramp up 1 -> 4 with dwell 3, ready always high.
        run_req(0, 4, 3);
        // Ramp down 6 -> 3 with delayed ready and no dwell.
        run_req(0, 6, 0);
        rdy_mode = 1;
        run_req(0, 3, 0);
        rdy_mode = 0;
        // Equal target from requester 1 moves the pointer back to 0.
        run_req(1, 3, 0);
        // Contention: req0 wins first, then req1.
        run_pair(8, 2, 1);
        run_req(0, 4, 0);
        // Pointer now at 1: req1 wins the next simultaneous pair.
        run_pair(1, 6, 2);

        // Reset while dwelling at ratio 3 on the way to 5.
        run_req(0, 1, 0);
        dwell = DW'(4);
        req_div[0*W +: W] = W'(5);
        push_txn(0, 5, 4);
        req_valid[0] = 1'b1;
        drive_until_accepted();
        budget = 0;
        do begin
            @(negedge clk);
            budget++;
        end while (!(cur_div == W'(3) && !div_valid && busy) && budget < 200);
        check("reach_dwell_at_3", cur_div, 3);
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        #1;
        check_reset_outputs("midramp_reset");
        step_q.delete();
        done_q.delete();
        acc_q.delete();
        m_cur = 1;
        m_rr  = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
        @(posedge clk);
        #1;
        run_req(0, 5, 4);

        // Top of range: 14 -> 15 in one step without wrapping.
        run_req(0, 14, 0);
        run_req(1, 15, 1);
        run_req(0, 15, 0);

        // Randomized requests, pairs and ready behaviour.
        for (int it = 0; it < 40; it++) begin
            rdy_mode = $urandom_range(0, 2);
            if ($urandom_range(0, 2) == 0)
                run_pair($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 3));
            else
                run_req($urandom_range(0, 1), $urandom_range(0, 15), $urandom_range(0, 3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #800000;
        $display("FAIL watchdog: actual timeout required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
